// File: rtl/id_ex_decode.sv
// id_ex_decode: RV32I(+MUL/DIVU) decode into the ID/EX pipeline register
// with stall (hold) and flush (bubble) control.
module id_ex_decode #(
   parameter int XLEN = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     InstrD,
   input  logic [XLEN-1:0] PCD,
   input  logic            ValidD,
   input  logic            StallE,
   input  logic            FlushE,
   output logic            ValidE,
   output logic            IllegalE,
   output logic            RegWriteE,
   output logic            MemWriteE,
   output logic            BranchE,
   output logic            JumpE,
   output logic [1:0]      ResultSrcE,
   output logic            ALUSrcE,
   output logic            ASrcPCE,
   output logic            SwapE,
   output logic [4:0]      ALUControlE,
   output logic [2:0]      funct3E,
   output logic [4:0]      Rs1E,
   output logic [4:0]      Rs2E,
   output logic [4:0]      RdE,
   output logic [XLEN-1:0] ImmExtE,
   output logic [XLEN-1:0] PCE
);
   typedef struct packed {
      logic            valid;
      logic            illegal;
      logic            reg_write;
      logic            mem_write;
      logic            branch;
      logic            jump;
      logic [1:0]      result_src;
      logic            alu_src;
      logic            a_src_pc;
      logic            swap;
      logic [4:0]      alu_ctrl;
      logic [2:0]      funct3;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
   } ex_t;

   logic [6:0]      op;
   logic [6:0]      f7;
   logic [2:0]      f3;
   logic            is_r, is_i, is_ld, is_st, is_b, is_jal, is_jalr, is_lui, is_aui;
   logic            illegal;
   logic [4:0]      alu_base;
   logic [4:0]      alu_rr;
   logic [31:0]     imm32;
   ex_t             dec;
   ex_t             e_d, e_q;
   logic [XLEN-1:0] pc_d, pc_q;

   always_comb begin
      op      = InstrD[6:0];
      f3      = InstrD[14:12];
      f7      = InstrD[31:25];
      is_r    = op == 7'b0110011;
      is_i    = op == 7'b0010011;
      is_ld   = op == 7'b0000011;
      is_st   = op == 7'b0100011;
      is_b    = op == 7'b1100011;
      is_jal  = op == 7'b1101111;
      is_jalr = op == 7'b1100111;
      is_lui  = op == 7'b0110111;
      is_aui  = op == 7'b0010111;
      case (f3)
         3'b000:         alu_base = 5'b00000;
         3'b001:         alu_base = 5'b00100;
         3'b010, 3'b011: alu_base = 5'b01110;
         3'b100:         alu_base = 5'b01010;
         3'b101:         alu_base = 5'b00101;
         3'b110:         alu_base = 5'b01001;
         default:        alu_base = 5'b01000;
      endcase
      alu_rr = !is_r                 ? alu_base :
               f7 == 7'b0000001      ? (f3 == 3'b000 ? 5'b00010 : 5'b00011) :
               f7 == 7'b0100000      ? 5'b00001 : alu_base;
      illegal = !(is_r | is_i | is_ld | is_st | is_b | is_jal | is_jalr | is_lui | is_aui)
              | (is_r & !(f7 == 7'b0000000 | (f7 == 7'b0100000 & f3 == 3'b000)
                          | (f7 == 7'b0000001 & (f3 == 3'b000 | f3 == 3'b101))))
              | (is_i & (f3 == 3'b001 | f3 == 3'b101) & f7 != 7'b0000000)
              | (is_b & f3[2:1] == 2'b01)
              | (is_jalr & f3 != 3'b000);
      imm32 = (is_i | is_ld | is_jalr) ? {{20{InstrD[31]}}, InstrD[31:20]} :
              is_st          ? {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]} :
              is_b           ? {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0} :
              is_jal         ? {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0} :
              (is_lui | is_aui) ? {InstrD[31:12], 12'b0} : 32'b0;
      dec.valid      = 1'b1;
      dec.illegal    = illegal;
      dec.reg_write  = !illegal & (is_r | is_i | is_ld | is_jal | is_jalr | is_lui | is_aui);
      dec.mem_write  = !illegal & is_st;
      dec.branch     = !illegal & is_b;
      dec.jump       = !illegal & (is_jal | is_jalr);
      dec.result_src = is_ld ? 2'b01 : (is_jal | is_jalr) ? 2'b10 : 2'b00;
      dec.alu_src    = is_i | is_ld | is_st | is_jalr | is_lui | is_aui;
      dec.a_src_pc   = is_aui;
      // set-less-than is evaluated as B>A, so operands are exchanged ahead of the ALU
      dec.swap       = (is_r | is_i) & f3[2:1] == 2'b01 & !(is_r & f7 == 7'b0000001);
      dec.alu_ctrl   = illegal ? 5'b00000 : (is_r | is_i) ? alu_rr :
                       is_b ? 5'b00001 : is_lui ? 5'b10000 : 5'b00000;
      dec.funct3     = f3;
      dec.rs1        = InstrD[19:15];
      dec.rs2        = InstrD[24:20];
      dec.rd         = InstrD[11:7];
      dec.imm        = XLEN'($signed(imm32));
      e_d  = FlushE ? '0 : StallE ? e_q : ValidD ? dec : '0;
      pc_d = (FlushE | StallE | !ValidD) ? pc_q : PCD;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q  <= '0;
         pc_q <= RESET_PC;
      end else begin
         e_q  <= e_d;
         pc_q <= pc_d;
      end
   end

   assign ValidE      = e_q.valid;
   assign IllegalE    = e_q.illegal;
   assign RegWriteE   = e_q.reg_write;
   assign MemWriteE   = e_q.mem_write;
   assign BranchE     = e_q.branch;
   assign JumpE       = e_q.jump;
   assign ResultSrcE  = e_q.result_src;
   assign ALUSrcE     = e_q.alu_src;
   assign ASrcPCE     = e_q.a_src_pc;
   assign SwapE       = e_q.swap;
   assign ALUControlE = e_q.alu_ctrl;
   assign funct3E     = e_q.funct3;
   assign Rs1E        = e_q.rs1;
   assign Rs2E        = e_q.rs2;
   assign RdE         = e_q.rd;
   assign ImmExtE     = e_q.imm;
   assign PCE         = pc_q;
endmodule

// File: tb/tb_id_ex_decode.sv
// tb_id_ex_decode: directed and randomized checks of id_ex_decode against
// a mnemonic-table reference model that encodes instructions from chosen operands.
module tb_id_ex_decode;
   localparam logic [31:0] RST_PC = 32'h0000_0080;

   logic        clk, rst_n, ValidD, StallE, FlushE;
   logic [31:0] InstrD, PCD;
   logic        ValidE, IllegalE, RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, ASrcPCE, SwapE;
   logic [1:0]  ResultSrcE;
   logic [4:0]  ALUControlE, Rs1E, Rs2E, RdE;
   logic [2:0]  funct3E;
   logic [31:0] ImmExtE, PCE;

   id_ex_decode #(.XLEN(32), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .PCD(PCD), .ValidD(ValidD),
      .StallE(StallE), .FlushE(FlushE), .ValidE(ValidE), .IllegalE(IllegalE),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
      .ResultSrcE(ResultSrcE), .ALUSrcE(ALUSrcE), .ASrcPCE(ASrcPCE), .SwapE(SwapE),
      .ALUControlE(ALUControlE), .funct3E(funct3E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .ImmExtE(ImmExtE), .PCE(PCE)
   );

   typedef struct packed {
      logic v, il, rw, mw, br, jp;
      logic [1:0] rs;
      logic as, apc, sw;
      logic [4:0] alu;
      logic [2:0] f3;
      logic [4:0] r1, r2, rd;
      logic [31:0] imm;
   } dec_t;

   // fmt: 0 R, 1 I, 2 I-shift, 3 S, 4 B, 5 J, 6 U, 7 no-format
   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      int fmt;
      logic [4:0] alu;
      logic rw, mw, br, jp;
      logic [1:0] rs;
      logic as, apc, sw, il;
   } kind_t;

   kind_t kinds[$];
   dec_t  m;
   logic [31:0] m_pc;
   int n_chk = 0, n_fail = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic kind_t kd(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, int fmt,
                                logic [4:0] alu, logic rw, mw, br, jp, logic [1:0] rs,
                                logic as, apc, sw, il);
      kind_t k;
      k.op = op; k.f3 = f3; k.f7 = f7; k.fmt = fmt; k.alu = alu;
      k.rw = rw; k.mw = mw; k.br = br; k.jp = jp; k.rs = rs;
      k.as = as; k.apc = apc; k.sw = sw; k.il = il;
      return k;
   endfunction

   function automatic dec_t mk(logic il, rw, mw, br, jp, logic [1:0] rs, logic as, apc, sw,
                               logic [4:0] alu, logic [2:0] f3, logic [4:0] r1, r2, rd,
                               logic [31:0] imm);
      dec_t d;
      d.v = 1'b1; d.il = il; d.rw = rw; d.mw = mw; d.br = br; d.jp = jp; d.rs = rs;
      d.as = as; d.apc = apc; d.sw = sw; d.alu = alu; d.f3 = f3;
      d.r1 = r1; d.r2 = r2; d.rd = rd; d.imm = imm;
      return d;
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_chk++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   task automatic check_all(input string t);
      chk({t, " ValidE"}, 32'(ValidE), 32'(m.v));
      chk({t, " IllegalE"}, 32'(IllegalE), 32'(m.il));
      chk({t, " RegWriteE"}, 32'(RegWriteE), 32'(m.rw));
      chk({t, " MemWriteE"}, 32'(MemWriteE), 32'(m.mw));
      chk({t, " BranchE"}, 32'(BranchE), 32'(m.br));
      chk({t, " JumpE"}, 32'(JumpE), 32'(m.jp));
      chk({t, " ResultSrcE"}, 32'(ResultSrcE), 32'(m.rs));
      chk({t, " ALUSrcE"}, 32'(ALUSrcE), 32'(m.as));
      chk({t, " ASrcPCE"}, 32'(ASrcPCE), 32'(m.apc));
      chk({t, " SwapE"}, 32'(SwapE), 32'(m.sw));
      chk({t, " ALUControlE"}, 32'(ALUControlE), 32'(m.alu));
      chk({t, " funct3E"}, 32'(funct3E), 32'(m.f3));
      chk({t, " Rs1E"}, 32'(Rs1E), 32'(m.r1));
      chk({t, " Rs2E"}, 32'(Rs2E), 32'(m.r2));
      chk({t, " RdE"}, 32'(RdE), 32'(m.rd));
      chk({t, " ImmExtE"}, ImmExtE, m.imm);
      chk({t, " PCE"}, PCE, m_pc);
   endtask

   task automatic step(input string t, input logic [31:0] ins, input logic [31:0] pc,
                       input logic vd, st, fl, input dec_t d);
      InstrD = ins; PCD = pc; ValidD = vd; StallE = st; FlushE = fl;
      @(posedge clk); #1;
      if (fl) m = '0;
      else if (!st) begin
         m = vd ? d : '0;
         if (vd) m_pc = pc;
      end
      check_all(t);
   endtask

   task automatic rand_instr(input kind_t k, output logic [31:0] ins, output dec_t d);
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm, r;
      rd = 5'($urandom_range(0, 31)); rs1 = 5'($urandom_range(0, 31)); rs2 = 5'($urandom_range(0, 31));
      r = $urandom();
      imm = 32'h0;
      case (k.fmt)
         0: ins = {k.f7, rs2, rs1, k.f3, rd, k.op};
         1: begin imm = 32'($urandom_range(0, 4095)) - 32'd2048; ins = {imm[11:0], rs1, k.f3, rd, k.op}; end
         2: begin imm = {20'h0, k.f7, 5'($urandom_range(0, 31))}; ins = {imm[11:0], rs1, k.f3, rd, k.op}; end
         3: begin imm = 32'($urandom_range(0, 4095)) - 32'd2048; ins = {imm[11:5], rs2, rs1, k.f3, imm[4:0], k.op}; end
         4: begin
            imm = (32'($urandom_range(0, 4095)) - 32'd2048) * 2;
            ins = {imm[12], imm[10:5], rs2, rs1, k.f3, imm[4:1], imm[11], k.op};
         end
         5: begin
            imm = (32'($urandom_range(0, (1 << 20) - 1)) - 32'(1 << 19)) * 2;
            ins = {imm[20], imm[10:1], imm[11], imm[19:12], rd, k.op};
         end
         6: begin imm = r & 32'hFFFF_F000; ins = {imm[31:12], rd, k.op}; end
         default: ins = {r[31:7], k.op};
      endcase
      d = mk(k.il, k.rw, k.mw, k.br, k.jp, k.rs, k.as, k.apc, k.sw, k.alu,
             ins[14:12], ins[19:15], ins[24:20], ins[11:7], imm);
   endtask

   initial begin
      logic [31:0] ins;
      dec_t d;
      // R-type
      kinds.push_back(kd(7'h33, 3'd0, 7'h00, 0, 5'b00000, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
      kinds.push_back(kd(7'h33, 3'd0, 7'h20, 0, 5'b00001, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
      kinds.push_back(kd(7'h33, 3'd1, 7'h00, 0, 5'b00100, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
      kinds.push_back(kd(7'h33, 3'd2, 7'h00, 0, 5'b01110, 1, 0, 0, 0, 2'b00, 0, 0, 1, 0));
      kinds.push_back(kd(7'h33, 3'd3, 7'h00, 0, 5'b01110, 1, 0, 0, 0, 2'b00, 0, 0, 1, 0));
      kinds.push_back(kd(7'h33, 3'd4, 7'h00, 0, 5'b01010, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
      kinds.push_back(kd(7'h33, 3'd5, 7'h00, 0, 5'b00101, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
      kinds.push_back(kd(7'h33, 3'd6, 7'h00, 0, 5'b01001, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
      kinds.push_back(kd(7'h33, 3'd7, 7'h00, 0, 5'b01000, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
      kinds.push_back(kd(7'h33, 3'd0, 7'h01, 0, 5'b00010, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
      kinds.push_back(kd(7'h33, 3'd5, 7'h01, 0, 5'b00011, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
      kinds.push_back(kd(7'h33, 3'd5, 7'h20, 0, 5'b00000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1));
      kinds.push_back(kd(7'h33, 3'd1, 7'h01, 0, 5'b00000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1));
      kinds.push_back(kd(7'h33, 3'd7, 7'h20, 0, 5'b00000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1));
      kinds.push_back(kd(7'h33, 3'd0, 7'h7F, 0, 5'b00000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1));
      // I-type ALU
      kinds.push_back(kd(7'h13, 3'd0, 7'h00, 1, 5'b00000, 1, 0, 0, 0, 2'b00, 1, 0, 0, 0));
      kinds.push_back(kd(7'h13, 3'd2, 7'h00, 1, 5'b01110, 1, 0, 0, 0, 2'b00, 1, 0, 1, 0));
      kinds.push_back(kd(7'h13, 3'd3, 7'h00, 1, 5'b01110, 1, 0, 0, 0, 2'b00, 1, 0, 1, 0));
      kinds.push_back(kd(7'h13, 3'd4, 7'h00, 1, 5'b01010, 1, 0, 0, 0, 2'b00, 1, 0, 0, 0));
      kinds.push_back(kd(7'h13, 3'd6, 7'h00, 1, 5'b01001, 1, 0, 0, 0, 2'b00, 1, 0, 0, 0));
      kinds.push_back(kd(7'h13, 3'd7, 7'h00, 1, 5'b01000, 1, 0, 0, 0, 2'b00, 1, 0, 0, 0));
      kinds.push_back(kd(7'h13, 3'd1, 7'h00, 2, 5'b00100, 1, 0, 0, 0, 2'b00, 1, 0, 0, 0));
      kinds.push_back(kd(7'h13, 3'd5, 7'h00, 2, 5'b00101, 1, 0, 0, 0, 2'b00, 1, 0, 0, 0));
      kinds.push_back(kd(7'h13, 3'd5, 7'h20, 2, 5'b00000, 0, 0, 0, 0, 2'b00, 1, 0, 0, 1));
      kinds.push_back(kd(7'h13, 3'd1, 7'h20, 2, 5'b00000, 0, 0, 0, 0, 2'b00, 1, 0, 0, 1));
      // memory, control flow, upper immediates, unknown opcodes
      kinds.push_back(kd(7'h03, 3'd2, 7'h00, 1, 5'b00000, 1, 0, 0, 0, 2'b01, 1, 0, 0, 0));
      kinds.push_back(kd(7'h23, 3'd2, 7'h00, 3, 5'b00000, 0, 1, 0, 0, 2'b00, 1, 0, 0, 0));
      kinds.push_back(kd(7'h63, 3'd0, 7'h00, 4, 5'b00001, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0));
      kinds.push_back(kd(7'h63, 3'd6, 7'h00, 4, 5'b00001, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0));
      kinds.push_back(kd(7'h63, 3'd2, 7'h00, 4, 5'b00000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1));
      kinds.push_back(kd(7'h6F, 3'd0, 7'h00, 5, 5'b00000, 1, 0, 0, 1, 2'b10, 0, 0, 0, 0));
      kinds.push_back(kd(7'h67, 3'd0, 7'h00, 1, 5'b00000, 1, 0, 0, 1, 2'b10, 1, 0, 0, 0));
      kinds.push_back(kd(7'h67, 3'd1, 7'h00, 1, 5'b00000, 0, 0, 0, 0, 2'b10, 1, 0, 0, 1));
      kinds.push_back(kd(7'h37, 3'd0, 7'h00, 6, 5'b10000, 1, 0, 0, 0, 2'b00, 1, 0, 0, 0));
      kinds.push_back(kd(7'h17, 3'd0, 7'h00, 6, 5'b00000, 1, 0, 0, 0, 2'b00, 1, 1, 0, 0));
      kinds.push_back(kd(7'h7F, 3'd0, 7'h00, 7, 5'b00000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1));
      kinds.push_back(kd(7'h0B, 3'd0, 7'h00, 7, 5'b00000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1));

      // asynchronous reset mid-cycle, checked before any further clock edge
      rst_n = 1'b1; InstrD = '0; PCD = '0; ValidD = 1'b0; StallE = 1'b0; FlushE = 1'b0;
      #8 rst_n = 1'b0;
      #1 m = '0; m_pc = RST_PC;
      check_all("reset");
      @(posedge clk); #1 rst_n = 1'b1;

      step("sub", 32'h40B5_0533, 32'h100, 1, 0, 0,
           mk(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 5'b00001, 3'd0, 5'd10, 5'd11, 5'd10, 32'h0));
      step("addi", 32'hFFF5_0513, 32'h104, 1, 0, 0,
           mk(0, 1, 0, 0, 0, 2'b00, 1, 0, 0, 5'b00000, 3'd0, 5'd10, 5'd31, 5'd10, 32'hFFFF_FFFF));
      step("sltu", {7'h00, 5'd7, 5'd6, 3'd3, 5'd5, 7'h33}, 32'h108, 1, 0, 0,
           mk(0, 1, 0, 0, 0, 2'b00, 0, 0, 1, 5'b01110, 3'd3, 5'd6, 5'd7, 5'd5, 32'h0));
      step("beq", 32'hFE00_0EE3, 32'h10C, 1, 0, 0,
           mk(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 5'b00001, 3'd0, 5'd0, 5'd0, 5'd29, 32'hFFFF_FFFC));
      step("jal", 32'h0080_00EF, 32'h110, 1, 0, 0,
           mk(0, 1, 0, 0, 1, 2'b10, 0, 0, 0, 5'b00000, 3'd0, 5'd0, 5'd8, 5'd1, 32'h8));
      for (int i = 0; i < 3; i++) begin
         rand_instr(kinds[$urandom_range(0, kinds.size() - 1)], ins, d);
         step("stall", ins, $urandom() & ~32'h3, 1, 1, 0, d);
      end
      step("stall_flush", 32'hFFF5_0513, 32'h200, 1, 1, 1,
           mk(0, 1, 0, 0, 0, 2'b00, 1, 0, 0, 5'b00000, 3'd0, 5'd10, 5'd31, 5'd10, 32'hFFFF_FFFF));
      step("sra", {7'h20, 5'd3, 5'd2, 3'd5, 5'd1, 7'h33}, 32'h204, 1, 0, 0,
           mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 5'b00000, 3'd5, 5'd2, 5'd3, 5'd1, 32'h0));
      step("bad_op", 32'hFFFF_FFFF, 32'h208, 1, 0, 0,
           mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 5'b00000, 3'd7, 5'd31, 5'd31, 5'd31, 32'h0));
      step("no_valid", 32'h40B5_0533, 32'h20C, 0, 0, 0,
           mk(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 5'b00001, 3'd0, 5'd10, 5'd11, 5'd10, 32'h0));

      for (int i = 0; i < 400; i++) begin
         rand_instr(kinds[$urandom_range(0, kinds.size() - 1)], ins, d);
         step("rand", ins, $urandom() & ~32'h3, $urandom_range(0, 7) != 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, d);
      end

      // reset landing in the middle of a stall leaves nothing behind
      step("pre_rst", 32'h40B5_0533, 32'h300, 1, 0, 0,
           mk(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 5'b00001, 3'd0, 5'd10, 5'd11, 5'd10, 32'h0));
      StallE = 1'b1;
      #2 rst_n = 1'b0;
      #1 m = '0; m_pc = RST_PC;
      check_all("rst_stall");
      @(posedge clk); #1 rst_n = 1'b1;
      step("post_rst_stall", 32'h0080_00EF, 32'h304, 1, 1, 0,
           mk(0, 1, 0, 0, 1, 2'b10, 0, 0, 0, 5'b00000, 3'd0, 5'd0, 5'd8, 5'd1, 32'h8));
      step("post_rst_load", 32'h0080_00EF, 32'h308, 1, 0, 0,
           mk(0, 1, 0, 0, 1, 2'b10, 0, 0, 0, 5'b00000, 3'd0, 5'd0, 5'd8, 5'd1, 32'h8));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
